dma_src_fifo: RTL and testbench
===============================

Name: dma_src_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO between the peripheral capture logic (write side) and the DMA write engine (read side).
- The DMA engine pops one word per granted cycle and samples rd_data in the same cycle it asserts rd_enable, so the head word must be presented combinationally whenever empty is low.
- Exposes a fill level and an almost-full threshold so the producer can throttle before overflow.

Parameters:
DATA_W, 32, data word width
DEPTH, 16, number of entries; must be a power of two, at least 2
ADDR_W, 4, log2(DEPTH); pointer index width
AFULL_LVL, 12, almost_full asserts when level >= AFULL_LVL

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_enable  in  1  producer push request
wr_data  in  DATA_W  word to push
full  out  1  FIFO holds DEPTH words
almost_full  out  1  level >= AFULL_LVL
rd_enable  in  1  consumer pop request (DMA)
rd_data  out  DATA_W  head word, valid while empty=0
empty  out  1  FIFO holds 0 words
level  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: push attempted while full (see Optional Feature)
underflow  out  1  sticky: pop attempted while empty (see Optional Feature)
err_clr  in  1  clears overflow/underflow (see Optional Feature)

Behaviour:
- Reset (reset=0, async): wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0. The storage array is not reset.
- Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = low ADDR_W bits equal and MSBs differ.
  - level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
  - All flags are registered-pointer derived; no combinational path from wr_enable/rd_enable to any flag.
- Push accepted iff wr_enable=1 and full=0. On acceptance, mem[wr_ptr[ADDR_W-1:0]] <= wr_data and wr_ptr increments at the clock edge.
- Pop accepted iff rd_enable=1 and empty=0. On acceptance, rd_ptr increments at the clock edge.
- rd_data = mem[rd_ptr[ADDR_W-1:0]] combinationally when empty=0, else all zeros.
  - Pop latency is 0 (data is in the same cycle as rd_enable).
  - Write-to-read latency is 1 cycle: a word pushed at edge N is visible and empty=0 after edge N.
- Simultaneous push and pop, neither rejected: both pointers advance and level is unchanged.
- Push while full is rejected even if a pop occurs in the same cycle; there is no pass-through when full.
- Pop while empty is rejected even if a push occurs in the same cycle; the pushed word becomes visible next cycle.
- Pointer wrap: the index bits roll over from DEPTH-1 to 0 and the MSB toggles. Behaviour must stay seamless across any number of wraps.
- Rejected requests change no pointer, level or data.
- Reset asserted mid-operation: contents are discarded and all outputs return to their reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow is set on any cycle with wr_enable=1 and full=1.
  - underflow is set on any cycle with rd_enable=1 and empty=1.
  - Both are sticky until an err_clr=1 cycle clears them at the next edge.
  - If a set condition and err_clr occur in the same cycle, set wins.
- Not defined: overflow and underflow are tied to 0 and err_clr is ignored. The ports remain present so the interface is identical in both builds.

Test Plan:
- Reset, then push 0xA0..0xA3 on 4 consecutive cycles with no pops -> level=4, empty=0 from the cycle after the first push, rd_data=0xA0.
- Pop 4 times back-to-back -> rd_data reads 0xA0, 0xA1, 0xA2, 0xA3 in the cycles rd_enable is high; then empty=1, rd_data=0, level=0.
- Push 16 words (DEPTH=16) -> almost_full=1 after the 12th push, full=1 after the 16th. A 17th push with data 0xFF is dropped, level stays 16, overflow=1 (macro defined).
- While full, assert wr_enable and rd_enable together -> pop accepted, push rejected, level=15, full=0.
- Continuous concurrent push/pop for 40 cycles at level 3 (pointers wrap at least twice) -> level stays 3, output order is exactly the input order, no flag glitches.
- Assert reset for 1 cycle mid-burst at level 7 -> immediately empty=1, level=0, full=0, overflow/underflow=0. The next push then reads back correctly.

Source files
------------

// File: rtl/dma_src_fifo.sv
// First-word-fall-through source FIFO between peripheral capture and the DMA write engine.
// Optional sticky overflow/underflow error flags are enabled by defining FIFO_ERR_FLAGS_EN.
module dma_src_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_enable,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_enable,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] AFULL_P = (ADDR_W+1)'(AFULL_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic              push, pop;

  // Flags come only from registered pointers, never from the request inputs.
  assign level       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                       (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign almost_full = (level >= AFULL_P);

  assign push = wr_enable && !full;
  assign pop  = rd_enable && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

`ifdef FIFO_ERR_FLAGS_EN
  // A set condition in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_enable && full) overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (rd_enable && empty) underflow <= 1'b1;
      else if (err_clr)       underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_dma_src_fifo.sv
// Self-checking bench for dma_src_fifo: queue-based reference model, per-cycle compare, directed plus random stimulus.
module tb_dma_src_fifo;
  localparam int DATA_W = 32, DEPTH = 16, ADDR_W = 4, AFULL_LVL = 12;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk, reset;
  logic wr_enable, rd_enable, err_clr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic full, almost_full, empty, overflow, underflow;
  logic [ADDR_W:0] level;

  dma_src_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL_LVL)) dut (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .rd_enable(rd_enable), .rd_data(rd_data), .empty(empty),
    .level(level), .overflow(overflow), .underflow(underflow), .err_clr(err_clr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just an ordered queue of accepted words.
  logic [DATA_W-1:0] q[$];
  bit ovf_m, unf_m;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      if (ERR_EN) begin
        if (wr_enable && was_full)       ovf_m = 1'b1;
        else if (err_clr)                ovf_m = 1'b0;
        if (rd_enable && was_empty)      unf_m = 1'b1;
        else if (err_clr)                unf_m = 1'b0;
      end
      if (rd_enable && !was_empty) void'(q.pop_front());
      if (wr_enable && !was_full)  q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    chk("level",       64'(level),       64'(q.size()));
    chk("empty",       64'(empty),       64'(q.size() == 0));
    chk("full",        64'(full),        64'(q.size() == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(q.size() >= AFULL_LVL));
    chk("rd_data",     64'(rd_data),     (q.size() != 0) ? 64'(q[0]) : 64'd0);
    chk("overflow",    64'(overflow),    64'(ovf_m));
    chk("underflow",   64'(underflow),   64'(unf_m));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_enable = 1'b0; rd_enable = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_data = '0;
    idle();
    #2;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Four pushes, no pops.
    for (int i = 0; i < 4; i++) begin
      wr_enable = 1'b1; wr_data = 32'hA0 + 32'(i);
      tick();
      if (i == 0) chk("empty_after_first_push", 64'(empty), 64'd0);
    end
    idle();
    chk("lvl4", 64'(level), 64'd4);
    chk("head_a0", 64'(rd_data), 64'hA0);

    // Four back-to-back pops; data valid in the same cycle as rd_enable.
    for (int i = 0; i < 4; i++) begin
      rd_enable = 1'b1;
      #1 chk("pop_data", 64'(rd_data), 64'hA0 + 64'(i));
      tick();
    end
    idle();
    chk("drained_empty", 64'(empty), 64'd1);
    chk("drained_rd0", 64'(rd_data), 64'd0);
    chk("drained_lvl", 64'(level), 64'd0);

    // Pop while empty, then pop+push while empty.
    rd_enable = 1'b1; tick();
    chk("underflow_set", 64'(underflow), 64'(ERR_EN));
    chk("lvl_after_underflow", 64'(level), 64'd0);
    wr_enable = 1'b1; wr_data = 32'h77; tick();
    idle();
    chk("push_during_empty_pop", 64'(level), 64'd1);
    chk("push_during_empty_data", 64'(rd_data), 64'h77);
    rd_enable = 1'b1; tick(); idle();
    err_clr = 1'b1; tick(); idle();
    chk("underflow_clr", 64'(underflow), 64'd0);

    // Fill to full.
    for (int i = 0; i < DEPTH; i++) begin
      wr_enable = 1'b1; wr_data = 32'hB0 + 32'(i);
      tick();
      if (i == AFULL_LVL - 2) chk("afull_below", 64'(almost_full), 64'd0);
      if (i == AFULL_LVL - 1) chk("afull_at",    64'(almost_full), 64'd1);
      if (i == DEPTH - 2)     chk("not_full_15", 64'(full), 64'd0);
    end
    chk("full_16", 64'(full), 64'd1);
    wr_data = 32'hFF; tick();
    idle();
    chk("full_drop_level", 64'(level), 64'd16);
    chk("overflow_set", 64'(overflow), 64'(ERR_EN));
    chk("full_head", 64'(rd_data), 64'hB0);

    // Push+pop while full: only the pop is accepted.
    wr_enable = 1'b1; wr_data = 32'hEE; rd_enable = 1'b1;
    #1 chk("full_pop_data", 64'(rd_data), 64'hB0);
    tick(); idle();
    chk("full_both_lvl", 64'(level), 64'd15);
    chk("full_both_full", 64'(full), 64'd0);

    // Drain to 3 and clear the sticky flags.
    rd_enable = 1'b1;
    repeat (12) tick();
    idle();
    chk("lvl3", 64'(level), 64'd3);
    chk("overflow_sticky", 64'(overflow), 64'(ERR_EN));
    err_clr = 1'b1; tick(); idle();
    chk("overflow_clr", 64'(overflow), 64'd0);

    // Streaming at constant level 3 across several pointer wraps.
    for (int i = 0; i < 40; i++) begin
      wr_enable = 1'b1; rd_enable = 1'b1; wr_data = $urandom;
      tick();
      chk("stream_lvl", 64'(level), 64'd3);
    end
    idle();

    // Build to 7, then async reset mid-burst.
    wr_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = $urandom; tick();
    end
    chk("lvl7", 64'(level), 64'd7);
    wr_enable = 1'b1; wr_data = 32'h1234;
    reset = 1'b0;
    #1;
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_unf", 64'(underflow), 64'd0);
    idle();
    tick();
    reset = 1'b1;
    wr_enable = 1'b1; wr_data = 32'h5A; tick(); idle();
    chk("post_rst_data", 64'(rd_data), 64'h5A);
    chk("post_rst_lvl", 64'(level), 64'd1);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 60; i++) begin
        automatic int wp = ph[0] ? 30 : 75;
        wr_enable = ($urandom_range(99) < 32'(wp));
        rd_enable = ($urandom_range(99) < 32'(100 - wp));
        err_clr   = ($urandom_range(15) == 0);
        wr_data   = $urandom;
        tick();
      end
    end
    idle();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
